// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared datapath ALU (ADD mode)
// through a request/grant handshake; one product bit retires per granted cycle.
module alu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] MulA,
  input  logic [WIDTH-1:0] MulB,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] ProdHi,
  output logic [WIDTH-1:0] ProdLo,
  output logic             AluReq,
  input  logic             AluGnt,
  output logic [2:0]       AluOp,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluCarryOut
);

  localparam logic [2:0]       OP_ADD   = 3'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          mcand_d = MulA;
          hi_d    = '0;
          lo_d    = MulB;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Without a grant the ALU belongs to someone else: hold everything.
        if (AluGnt) begin
          if (lo_q[0]) begin
            hi_d = {AluCarryOut, AluResult[WIDTH-1:1]};
            lo_d = {AluResult[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = {1'b0, hi_q[WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Ready  = (state_q == S_IDLE);
    Done   = (state_q == S_DONE);
    AluReq = (state_q == S_RUN);
    ProdHi = hi_q;
    ProdLo = lo_q;
    // Operands are quiet outside RUN so the datapath mux sees zeros when idle.
    AluOp  = AluReq ? OP_ADD  : 3'd0;
    AluA   = AluReq ? hi_q    : '0;
    AluB   = AluReq ? mcand_q : '0;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle unsigned multiply sequencer for the 32-bit datapath.
- Computes a 64-bit product by shift-add, 32 iterations.
- Does not instantiate its own adder. It borrows the datapath's shared 32-bit ALU in ADD mode (Op=3'd2) through a request/grant handshake, and returns {ProdHi, ProdLo} to the register-file/HI-LO path.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a multiply; sampled only while Ready=1.
- MulA  input  WIDTH  multiplicand; latched on accepted Start.
- MulB  input  WIDTH  multiplier; latched on accepted Start.
- Ready  output  1  high in IDLE only.
- Done  output  1  one-cycle pulse; product valid.
- ProdHi  output  WIDTH  upper half of product.
- ProdLo  output  WIDTH  lower half of product.
- AluReq  output  1  requests the shared ALU; high throughout RUN.
- AluGnt  input  1  ALU granted this cycle (from datapath arbiter).
- AluOp  output  3  ALU opcode; 3'd2 while AluReq=1, else 3'd0.
- AluA  output  WIDTH  ALU operand A = ProdHi register while AluReq=1, else 0.
- AluB  output  WIDTH  ALU operand B = latched multiplicand while AluReq=1, else 0.
- AluResult  input  WIDTH  ALU Result (combinational from AluA/AluB/AluOp).
- AluCarryOut  input  1  ALU CarryOut for ADD.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge): state=IDLE, counter=0, multiplicand reg=0, ProdHi=0, ProdLo=0, Done=0, AluReq=0. Ready=1 after reset. Reset overrides Start and any in-flight operation; a partial product is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - Ready=1.
  - Start=1 at an edge: Mcand<=MulA, ProdHi<=0, ProdLo<=MulB, counter<=0, state<=RUN.
- RUN:
  - AluReq=1, Ready=0.
  - A step happens only in cycles with AluGnt=1.
  - Step with ProdLo[0]=1: {ProdHi,ProdLo} <= {AluCarryOut, AluResult, ProdLo[WIDTH-1:1]}, i.e. the (2*WIDTH+1)-bit {carry,sum,lo} shifted right by 1.
  - Step with ProdLo[0]=0: {ProdHi,ProdLo} <= {1'b0, ProdHi, ProdLo[WIDTH-1:1]}. ALU output is ignored.
  - Each step: counter<=counter+1. The step taken with counter==WIDTH-1 moves state to DONE.
  - AluGnt=0 is a stall: all registers hold, AluReq stays 1, no timeout.
  - Grant may drop and return any number of times mid-operation. The result must be identical to the no-stall case.
- DONE:
  - Done=1 for exactly one cycle, Ready=0, AluReq=0.
  - Next state is IDLE unconditionally.
- ProdHi/ProdLo hold the final product from DONE until the next accepted Start or Reset.
- Latency with AluGnt tied high: Start accepted at edge N. RUN occupies cycles N+1..N+WIDTH. Done=1 in cycle N+WIDTH+1. Ready=1 again in cycle N+WIDTH+2.
- Start while Ready=0 (RUN or DONE) is ignored. It is not queued.
- Start asserted in the same cycle Ready returns to 1 is accepted normally.
- Arithmetic is unsigned only, with no overflow: the product always fits 2*WIDTH bits. The carry from the ALU is the only bit WIDTH+1 source.
- ALU sharing: AluA/AluB/AluOp are driven only while AluReq=1. The datapath mux must select the sequencer's operands when it asserts AluGnt.

Test Plan:
- Basic multiply: Reset, AluGnt=1, MulA=7, MulB=9, Start pulse → Done in 33rd cycle after acceptance; ProdHi=0, ProdLo=63; Ready returns next cycle.
- Carry path: MulA=MulB=32'hFFFFFFFF → ProdHi=32'hFFFFFFFE, ProdLo=32'h00000001. Also MulA=32'h80000000, MulB=2 → ProdHi=1, ProdLo=0.
- Zero and identity: MulA=0, MulB=32'h12345678 → product 0; MulA=32'h12345678, MulB=1 → ProdHi=0, ProdLo=32'h12345678. Both with the same 33-cycle latency.
- Grant stalls: MulA=32'h0001_0001, MulB=32'h0003_0003, AluGnt toggled pseudo-randomly (~50%) → product 64'h0000_0003_0006_0003. Done occurs exactly 32 granted RUN cycles after acceptance; AluReq stays high throughout RUN; AluOp=2 whenever AluReq=1.
- Busy Start ignored: Start held high during RUN and DONE with changing MulA/MulB → product reflects only the first accepted operands; Done pulses once; a new Start in the first Ready cycle is accepted.
- Reset mid-op: Reset for one cycle at iteration 10 → next cycle shows Ready=1, ProdHi=ProdLo=0, AluReq=0, no Done. A subsequent 5*5 gives ProdLo=25.
